counter_ram: RTL
================

COUNTER_RAM -- requirements
Module: counter_ram

Interface
REQ-001 SHALL have parameter DPW, default 10, meaning address width; depth is 2**DPW words.
REQ-002 SHALL have parameter DW, default 32, meaning counter word width.
REQ-003 SHALL have parameter IW, default 16, meaning increment width, with IW <= DW.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk  in  1  sole clock, all logic on posedge.
REQ-005 SHALL have rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have clr_req  in  1  one-cycle pulse that starts a full clear sweep.
REQ-007 SHALL have busy  out  1  high while a clear sweep runs.
REQ-008 SHALL have upd_valid / upd_ready  in / out  1 / 1  update handshake.
REQ-009 SHALL have upd_addr  in  DPW  counter to update.
REQ-010 SHALL have upd_inc  in  IW  unsigned increment.
REQ-011 SHALL have rsp_valid  out  1  update result strobe.
REQ-012 SHALL have rsp_val  out  DW  post-update counter value.
REQ-013 SHALL have rsp_sat  out  1  saturation occurred on this update.
REQ-014 SHALL have qry_valid / qry_ready  in / out  1 / 1  query handshake.
REQ-015 SHALL have qry_addr  in  DPW  counter to read.
REQ-016 SHALL have qry_rsp_valid  out  1  query result strobe.
REQ-017 SHALL have qry_data  out  DW  queried counter value.

Function
REQ-018 SHALL accept an update or query only in a cycle where its valid and ready are both high.
REQ-019 SHALL drive upd_ready = qry_ready = !busy, with no other backpressure.
REQ-020 SHALL implement the update as a two-stage read-modify-write.
- S0 is the accept cycle T; the read is issued.
- S1 is cycle T+1; the sum is computed and written at the end of T+1.
REQ-021 SHALL assert rsp_valid in T+2, carrying rsp_val and rsp_sat for the update accepted at T.
REQ-022 SHALL compute new = old + zero-extended upd_inc, clamped to 2**DW-1.
- rsp_sat SHALL be 1 iff the clamp applied.
- upd_inc = 0 SHALL be a legal read-through and never sets rsp_sat.
REQ-023 SHALL sustain one update per cycle, including back-to-back and every-cycle updates to the same address.
- Each update SHALL observe the results of all earlier accepted updates.
- Correctness SHALL be achieved by forwarding the S1 result; stalls are not permitted.
REQ-024 SHALL return qry_data with qry_rsp_valid in T+1 for a query accepted at T.
- The value returned SHALL reflect all update writes that committed at or before the end of T-1.
- An update write committing at the end of T SHALL NOT be visible to that query.
REQ-025 SHALL allow an update and a query in the same cycle to the same or different addresses, each per its own rule.
REQ-026 SHALL run the clear sweep FSM with states IDLE and CLEAR.
- Entry: rst_n deassertion, or clr_req while IDLE.
- CLEAR writes 0 to address 0..2**DPW-1, one per cycle, then returns to IDLE.
- busy SHALL be high for exactly 2**DPW cycles.
REQ-027 SHALL complete in-flight updates (S0/S1) normally when clr_req arrives in IDLE.
- Their writes SHALL land before the sweep overwrites those addresses.
- Their responses SHALL still be issued.
REQ-028 SHALL ignore clr_req while in CLEAR; the sweep is not restarted.
REQ-029 SHALL return every counter as 0 when queried after busy falls, unless it has been updated since.

Reset
REQ-030 SHALL, while rst_n = 0 at a clock edge:
- drop all in-flight updates and queries with no response;
- drive rsp_valid, rsp_sat, qry_rsp_valid = 0, rsp_val = 0, qry_data = 0, busy = 1;
- hold the sweep address at 0.
REQ-031 SHALL start the sweep on the first edge with rst_n = 1, with busy remaining high for 2**DPW cycles.
REQ-032 SHALL treat reset asserted mid-sweep or mid-update identically to REQ-030.

Verification (DPW=4, DW=8, IW=4)
REQ-033 Reset then idle -> busy high for 16 cycles after rst_n rises; queries of addr 0..15 then return 0.
REQ-034 Updates (addr 3, +5) at T, T+1, T+2 -> rsp_val 5, 10, 15 at T+2, T+3, T+4; query at T+5 returns 15.
REQ-035 Counter at 250, update +15 -> rsp_val 255, rsp_sat 1; further update +1 -> rsp_val 255, rsp_sat 1.
REQ-036 Update (addr 7, +2) at T with query addr 7 at T+1 -> query returns old value; query at T+2 returns old+2.
REQ-037 clr_req the cycle after accepting an update to addr 9 -> rsp still issued; after busy falls, addr 9 reads 0.
REQ-038 rst_n low for 1 cycle mid-stream -> no rsp_valid for the dropped ops, busy high 16 cycles, all counters read 0.

Source files
------------

// File: rtl/counter_ram.sv
// counter_ram: array of saturating counters with pipelined read-modify-write updates, queries and a clear sweep
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   clr_req, busy    clear sweep start pulse, high while the sweep runs
//   upd_*            update handshake, address and unsigned increment
//   rsp_*            update result strobe, post-update value, saturation flag
//   qry_*            query handshake, address, result strobe and data
module counter_ram #(
  parameter int DPW = 10,
  parameter int DW  = 32,
  parameter int IW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_req,
  output logic           busy,
  input  logic           upd_valid,
  output logic           upd_ready,
  input  logic [DPW-1:0] upd_addr,
  input  logic [IW-1:0]  upd_inc,
  output logic           rsp_valid,
  output logic [DW-1:0]  rsp_val,
  output logic           rsp_sat,
  input  logic           qry_valid,
  output logic           qry_ready,
  input  logic [DPW-1:0] qry_addr,
  output logic           qry_rsp_valid,
  output logic [DW-1:0]  qry_data
);
  typedef enum logic {IDLE, CLEAR} st_t;
  st_t            st_q, st_d;
  logic [DPW-1:0] clr_addr_q, clr_addr_d;
  logic [DW-1:0]  mem [2**DPW];
  logic           upd_acc, qry_acc;
  logic           s1_vld_q;
  logic [DPW-1:0] s1_addr_q;
  logic [IW-1:0]  s1_inc_q;
  logic [DW-1:0]  rd_q;
  logic           fw_vld_q;
  logic [DPW-1:0] fw_addr_q;
  logic [DW-1:0]  fw_val_q;
  logic [DW-1:0]  old_val, new_val;
  logic [DW:0]    sum;
  logic           sat;
  logic           rsp_valid_q, rsp_sat_q, qry_rsp_valid_q;
  logic [DW-1:0]  rsp_val_q, qry_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      st_q       <= st_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    st_d       = (st_q == IDLE) ? (clr_req ? CLEAR : IDLE) : (&clr_addr_q ? IDLE : CLEAR);
    clr_addr_d = (st_q == CLEAR) ? clr_addr_q + 1'b1 : '0;
  end

  always_comb begin
    busy = (st_q == CLEAR);
  end

  assign upd_ready = !busy;
  assign qry_ready = !busy;
  assign upd_acc   = upd_valid && upd_ready;
  assign qry_acc   = qry_valid && qry_ready;

  // The RAM read issued in S0 cannot see the write committing in the same
  // cycle, so the result just written by the previous S1 is forwarded.
  assign old_val = (fw_vld_q && fw_addr_q == s1_addr_q) ? fw_val_q : rd_q;
  assign sum     = {1'b0, old_val} + {{(DW + 1 - IW){1'b0}}, s1_inc_q};
  assign sat     = sum[DW];
  assign new_val = sat ? '1 : sum[DW-1:0];

  // A sweep write wins over a trailing update write; the sweep zeroes every
  // address afterwards anyway, so the dropped update value is never visible.
  always_ff @(posedge clk) begin
    rd_q <= mem[upd_addr];
    if (rst_n && busy) mem[clr_addr_q] <= '0;
    else if (rst_n && s1_vld_q) mem[s1_addr_q] <= new_val;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q        <= 1'b0;
      s1_addr_q       <= '0;
      s1_inc_q        <= '0;
      fw_vld_q        <= 1'b0;
      fw_addr_q       <= '0;
      fw_val_q        <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_val_q       <= '0;
      rsp_sat_q       <= 1'b0;
      qry_rsp_valid_q <= 1'b0;
      qry_data_q      <= '0;
    end else begin
      s1_vld_q        <= upd_acc;
      s1_addr_q       <= upd_addr;
      s1_inc_q        <= upd_inc;
      fw_vld_q        <= s1_vld_q;
      fw_addr_q       <= s1_addr_q;
      fw_val_q        <= new_val;
      rsp_valid_q     <= s1_vld_q;
      rsp_sat_q       <= s1_vld_q && sat;
      qry_rsp_valid_q <= qry_acc;
      if (s1_vld_q) rsp_val_q <= new_val;
      if (qry_acc) qry_data_q <= mem[qry_addr];
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_val       = rsp_val_q;
  assign rsp_sat       = rsp_sat_q;
  assign qry_rsp_valid = qry_rsp_valid_q;
  assign qry_data      = qry_data_q;
endmodule
